// File: rtl/axil_ps2_rx.sv
// PS/2 device-to-host receiver with an AXI4-Lite register front end.
// Pins are synchronized and deglitched, deframed, then bytes are queued in a FIFO.
module axil_ps2_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        control_aclk,
  input  logic        control_aresetn,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  input  logic [7:0]  control_awaddr,
  input  logic        control_awvalid,
  output logic        control_awready,
  input  logic [31:0] control_wdata,
  input  logic        control_wvalid,
  output logic        control_wready,
  output logic [1:0]  control_bresp,
  output logic        control_bvalid,
  input  logic        control_bready,
  input  logic [7:0]  control_araddr,
  input  logic        control_arvalid,
  output logic        control_arready,
  output logic [31:0] control_rdata,
  output logic [1:0]  control_rresp,
  output logic        control_rvalid,
  input  logic        control_rready,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    ck_sync_q, ck_sync_d, dt_sync_q, dt_sync_d;
  logic          filt_q, filt_d, stb_q, stb_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shr_q, shr_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          din, timeout, push, perr_new, ferr_new;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          empty, full, push_ok, flush, clr, pop;
  logic          perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d, irq_en_q, irq_en_d, irq_d;
  logic          awready_q, awready_d, bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          wr_acc, rd_acc;
  logic [5:0]    widx, ridx;
  logic          unused_ok;

  assign unused_ok = ^{control_wdata[31:3], control_awaddr[1:0], control_araddr[1:0]};

  // Clock filter: a new level must persist FILTER_LEN cycles; any reversion restarts the count.
  always_comb begin
    ck_sync_d = {ck_sync_q[0], ps2_clk_i};
    dt_sync_d = {dt_sync_q[0], ps2_data_i};
    filt_d    = filt_q;
    fcnt_d    = '0;
    stb_d     = 1'b0;
    if (ck_sync_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = ck_sync_q[1];
        stb_d  = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign din     = dt_sync_q[1];
  assign timeout = (state_q != IDLE) && !stb_q && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge control_aclk or negedge control_aresetn) begin
    if (!control_aresetn) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      shr_q   <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shr_q   <= shr_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shr_d   = shr_q;
    par_d   = par_q;
    tmo_d   = (state_q == IDLE || stb_q) ? '0 : tmo_q + 1'b1;
    if (timeout) begin
      state_d = IDLE;
    end else if (stb_q) begin
      case (state_q)
        IDLE:   if (!din) begin state_d = DATA; bcnt_d = '0; end
        DATA: begin
          shr_d  = {din, shr_q[7:1]};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin par_d = din; state_d = STOP; end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    push     = 1'b0;
    perr_new = 1'b0;
    ferr_new = 1'b0;
    if (timeout) ferr_new = 1'b1;
    else if (stb_q && state_q == STOP) begin
      if (!din)                 ferr_new = 1'b1;
      else if (!(^{shr_q, par_q})) perr_new = 1'b1;
      else                      push = 1'b1;
    end
  end

  assign level  = wr_ptr_q - rd_ptr_q;
  assign empty  = (level == '0);
  assign full   = (level == (AW+1)'(FIFO_DEPTH));
  assign wr_acc = awready_q & control_awvalid & control_wvalid;
  assign rd_acc = arready_q & control_arvalid;
  assign widx   = control_awaddr[7:2];
  assign ridx   = control_araddr[7:2];
  assign flush  = wr_acc && widx == 6'd2 && control_wdata[1];
  assign clr    = wr_acc && widx == 6'd2 && control_wdata[2];
  assign pop    = rd_acc && ridx == 6'd0 && !empty;
  // Full is judged on registered state, so a same-cycle pop does not rescue a push.
  assign push_ok = push && !full && !flush;

  always_comb begin
    wr_ptr_d  = flush ? '0 : wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d  = flush ? '0 : rd_ptr_q + (AW+1)'(pop);
    perr_d    = (perr_q & ~clr) | perr_new;
    ferr_d    = (ferr_q & ~clr) | ferr_new;
    ovf_d     = (ovf_q & ~clr) | (push & full & ~flush);
    irq_en_d  = (wr_acc && widx == 6'd2) ? control_wdata[0] : irq_en_q;
    irq_d     = irq_en_q & ~empty;
    awready_d = control_awvalid & control_wvalid & ~bvalid_q & ~awready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (wr_acc) begin
      bvalid_d = 1'b1;
      bresp_d  = (widx <= 6'd2) ? 2'b00 : 2'b10;
    end else if (control_bready) begin
      bvalid_d = 1'b0;
    end
    arready_d = control_arvalid & ~rvalid_q & ~arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    if (rd_acc) begin
      rvalid_d = 1'b1;
      rresp_d  = 2'b00;
      case (ridx)
        6'd0: rdata_d = {empty, 23'b0, empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]]};
        6'd1: rdata_d = {17'b0, 7'(level), 3'b0, ovf_q, ferr_q, perr_q, full, ~empty};
        6'd2: rdata_d = {31'b0, irq_en_q};
        default: begin rdata_d = '0; rresp_d = 2'b10; end
      endcase
    end else if (control_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge control_aclk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shr_q;
  end

  always_ff @(posedge control_aclk or negedge control_aresetn) begin
    if (!control_aresetn) begin
      ck_sync_q <= 2'b11;
      dt_sync_q <= 2'b11;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      stb_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      irq       <= 1'b0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      ck_sync_q <= ck_sync_d;
      dt_sync_q <= dt_sync_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      stb_q     <= stb_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
      irq       <= irq_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign control_awready = awready_q;
  assign control_wready  = awready_q;
  assign control_bvalid  = bvalid_q;
  assign control_bresp   = bresp_q;
  assign control_arready = arready_q;
  assign control_rvalid  = rvalid_q;
  assign control_rresp   = rresp_q;
  assign control_rdata   = rdata_q;
endmodule

// File: tb/tb_axil_ps2_rx.sv
// Bench for axil_ps2_rx: random PS/2 frames and register traffic scored against a queue model.
`timescale 1ns/1ps
module tb_axil_ps2_rx;
  localparam int DEPTH = 16, FLEN = 4, TMO = 300, HALF = 20;

  logic clk = 1'b0, rst_n = 1'b0, ps2c = 1'b1, ps2d = 1'b1;
  logic [7:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  axil_ps2_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO)) dut (
    .control_aclk(clk), .control_aresetn(rst_n), .ps2_clk_i(ps2c), .ps2_data_i(ps2d),
    .control_awaddr(awaddr), .control_awvalid(awvalid), .control_awready(awready),
    .control_wdata(wdata), .control_wvalid(wvalid), .control_wready(wready),
    .control_bresp(bresp), .control_bvalid(bvalid), .control_bready(bready),
    .control_araddr(araddr), .control_arvalid(arvalid), .control_arready(arready),
    .control_rdata(rdata), .control_rresp(rresp), .control_rvalid(rvalid),
    .control_rready(rready), .irq(irq));

  int nvec = 0, nerr = 0;
  logic [7:0] mq[$];
  bit m_perr = 0, m_ferr = 0, m_ovf = 0, m_irqen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int n = mq.size();
    return {17'b0, 7'(n), 3'b0, m_ovf, m_ferr, m_perr, n == DEPTH, n != 0};
  endfunction

  // Bit-serial device frame: start, 8 data LSB first, odd parity, stop.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    repeat (2*HALF) @(negedge clk);
    if (nbits == 11) begin
      if (bad_stop) m_ferr = 1;
      else if (bad_par) m_perr = 1;
      else if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back(b);
    end
  endtask

  task automatic axi_wr(input logic [7:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("awready", {31'b0, awready}, 1);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid", {31'b0, bvalid}, 1);
    resp = bresp;
    bready = 1;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("arready", {31'b0, arready}, 1);
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rvalid", {31'b0, rvalid}, 1);
    d = rdata; resp = rresp;
    rready = 1;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic ctl_wr(input logic [2:0] v);
    logic [1:0] r;
    axi_wr(8'h08, {29'b0, v}, r);
    chk("ctl_bresp", {30'b0, r}, 0);
    m_irqen = v[0];
    if (v[1]) mq.delete();
    if (v[2]) begin m_perr = 0; m_ferr = 0; m_ovf = 0; end
  endtask

  task automatic st_check(input string tag);
    logic [31:0] d; logic [1:0] r;
    axi_rd(8'h04, d, r);
    chk(tag, d, exp_status());
    chk("irq_lvl", {31'b0, irq}, {31'b0, m_irqen && mq.size() != 0});
  endtask

  task automatic rx_read(input string tag);
    logic [31:0] d, e; logic [1:0] r; logic [7:0] h;
    if (mq.size() == 0) e = 32'h8000_0000;
    else begin h = mq.pop_front(); e = {24'b0, h}; end
    axi_rd(8'h00, d, r);
    chk(tag, d, e);
    chk("rx_rresp", {30'b0, r}, 0);
  endtask

  initial begin
    logic [31:0] d; logic [1:0] r; logic [7:0] h; int op;
    // valids held high during reset: nothing may be accepted
    awvalid = 1; wvalid = 1; arvalid = 1;
    repeat (3) @(negedge clk);
    chk("rst_awready", {31'b0, awready}, 0);
    chk("rst_wready", {31'b0, wready}, 0);
    chk("rst_arready", {31'b0, arready}, 0);
    chk("rst_bvalid", {31'b0, bvalid}, 0);
    chk("rst_rvalid", {31'b0, rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", {28'b0, bresp, rresp}, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    rst_n = 1;
    st_check("st_reset");

    send_frame(8'h1C, 0, 0, 11);
    axi_rd(8'h04, d, r);
    chk("st_1c", d, 32'h0000_0101);
    rx_read("rx_1c");
    chk("rx_1c_const", d, 32'h0000_0101);
    axi_rd(8'h04, d, r);
    chk("st_after_pop", d, 32'h0);

    send_frame(8'hA5, 1, 0, 11);
    axi_rd(8'h04, d, r);
    chk("st_par", d, 32'h0000_0004);
    ctl_wr(3'b100);
    st_check("st_par_clr");

    send_frame(8'h3C, 0, 0, 5);
    repeat (TMO + 20) @(negedge clk);
    m_ferr = 1;
    st_check("st_timeout");
    send_frame(8'h55, 0, 0, 11);
    rx_read("rx_55");
    ctl_wr(3'b100);

    for (int i = 0; i < 17; i++) send_frame(8'($urandom), 0, 0, 11);
    axi_rd(8'h04, d, r);
    chk("st_ovf", d, 32'h0000_1013);
    for (int i = 0; i < 16; i++) rx_read("rx_fifo");
    rx_read("rx_empty");
    ctl_wr(3'b100);

    ctl_wr(3'b001);
    send_frame(8'($urandom), 0, 0, 11);
    chk("irq_on", {31'b0, irq}, 1);
    axi_rd(8'h10, d, r);
    chk("bad_rdata", d, 0);
    chk("bad_rresp", {30'b0, r}, 2'b10);
    axi_wr(8'h0C, 32'h7, r);
    chk("bad_bresp", {30'b0, r}, 2'b10);
    @(negedge clk);
    araddr = 8'h00; arvalid = 1;
    for (int n = 0; n < 20 && !arready; n++) @(negedge clk);
    @(negedge clk);
    arvalid = 0;
    h = mq.pop_front();
    chk("irq_hold", {31'b0, irq}, 1);
    chk("rx_irq", rdata, {24'b0, h});
    rready = 1;
    @(negedge clk);
    rready = 0;
    chk("irq_drop", {31'b0, irq}, 0);

    // short low pulse on the clock with data low must not start a frame
    ps2d = 0; ps2c = 0;
    repeat (2) @(negedge clk);
    ps2c = 1; ps2d = 1;
    repeat (TMO + 40) @(negedge clk);
    st_check("st_glitch");
    send_frame(8'($urandom), 0, 0, 11);
    rx_read("rx_glitch");

    @(negedge clk);
    awaddr = 8'h08; wdata = 32'h1; awvalid = 1; wvalid = 1;
    for (int n = 0; n < 20 && !awready; n++) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bhold_awready", {31'b0, awready}, 0);
      chk("bhold_bvalid", {31'b0, bvalid}, 1);
      @(negedge clk);
    end
    awvalid = 0; wvalid = 0; bready = 1;
    @(negedge clk);
    bready = 0;
    m_irqen = 1;
    st_check("st_bhold");

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      send_frame(8'($urandom), op == 0, op == 1, 11);
      op = $urandom_range(0, 6);
      case (op)
        0, 1, 2: rx_read("rx_rand");
        3: st_check("st_rand");
        4: ctl_wr(3'($urandom_range(0, 7)));
        5: begin
          axi_rd(8'h0C, d, r);
          chk("bad_rd_rand", {r, d[29:0]}, {2'b10, 30'b0});
        end
        default: ;
      endcase
      chk("irq_rand", {31'b0, irq}, {31'b0, m_irqen && mq.size() != 0});
    end
    st_check("st_final");
    while (mq.size() != 0) rx_read("rx_drain");
    rx_read("rx_drain_empty");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
